// File: rtl/alu16_pkg.sv
// alu16_pkg: shared constants for the 16-bit multi-cycle ALU.
//   W        - datapath width (16)
//   op_e     - operation codes
//   state_e  - control FSM states
//   is_iter_op() - true for ops that run on the iterative datapath
// Optional feature macro: ALU16_DIV_EN (enables unsigned divide on op E).
package alu16_pkg;

    localparam int unsigned W = 16;

    typedef enum logic [3:0] {
        OP_PASS_S = 4'h0,
        OP_PASS_T = 4'h1,
        OP_ADD    = 4'h2,
        OP_SUB    = 4'h3,
        OP_INC    = 4'h4,
        OP_DEC    = 4'h5,
        OP_AND    = 4'h6,
        OP_OR     = 4'h7,
        OP_XOR    = 4'h8,
        OP_NOT    = 4'h9,
        OP_SHL    = 4'hA,
        OP_SHR    = 4'hB,
        OP_ASR    = 4'hC,
        OP_MUL    = 4'hD,
        OP_DIV    = 4'hE,
        OP_RSVD   = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU16_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu16_mc_if.sv
// alu16_mc_if: request/result bus of the multi-cycle ALU.
//   start, op, S, T          - request (driven by master)
//   Y_lo, Y_hi, busy, done,
//   C, V, N, Z               - result and status (driven by slave/ALU)
interface alu16_mc_if;
    import alu16_pkg::*;

    logic         start;
    logic [3:0]   op;
    logic [W-1:0] S;
    logic [W-1:0] T;
    logic [W-1:0] Y_lo;
    logic [W-1:0] Y_hi;
    logic         busy;
    logic         done;
    logic         C;
    logic         V;
    logic         N;
    logic         Z;

    modport master (
        output start, op, S, T,
        input  Y_lo, Y_hi, busy, done, C, V, N, Z
    );

    modport slave (
        input  start, op, S, T,
        output Y_lo, Y_hi, busy, done, C, V, N, Z
    );

endinterface

// File: rtl/alu16_iter.sv
// alu16_iter: iterative datapath, one step per cycle, 16 steps.
//   MUL: shift-add, {o_hi,o_lo} holds the 32-bit product after step 16.
//   DIV: restoring shift-subtract, o_lo = quotient, o_hi = remainder.
// Ports: i_clk, i_rst_n (async, active low), i_load (latch operands),
//   i_step (advance one iteration), i_div (divide mode, ALU16_DIV_EN only),
//   i_a/i_b (operands), o_last (current step is the 16th),
//   o_hi/o_lo (value after the current step).
// Macro ALU16_DIV_EN: adds the divide path and the i_div port.
module alu16_iter
    import alu16_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_step,
`ifdef ALU16_DIV_EN
    input  logic         i_div,
`endif
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_last,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_m;
    logic [3:0]   r_cnt;
    logic [W:0]   w_sum;
`ifdef ALU16_DIV_EN
    logic         r_div;
    logic [W:0]   w_shift;
    logic         w_ge;
`endif

    assign o_last = (r_cnt == 4'd15);

    always_comb begin
        // multiplier sits in r_lo and is consumed LSB first
        w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        o_hi  = w_sum[W:1];
        o_lo  = {w_sum[0], r_lo[W-1:1]};
`ifdef ALU16_DIV_EN
        w_shift = {r_hi, r_lo[W-1]};
        w_ge    = (w_shift >= {1'b0, r_m});
        if (r_div) begin
            // difference is below the divisor, so 16 bits suffice
            o_hi = w_ge ? (w_shift[W-1:0] - r_m) : w_shift[W-1:0];
            o_lo = {r_lo[W-2:0], w_ge};
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_cnt <= '0;
`ifdef ALU16_DIV_EN
            r_div <= 1'b0;
`endif
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_m   <= i_b;
            r_cnt <= '0;
`ifdef ALU16_DIV_EN
            r_div <= i_div;
`endif
        end else if (i_step) begin
            r_hi  <= o_hi;
            r_lo  <= o_lo;
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/alu16_mc.sv
// alu16_mc: 16-bit ALU with single-cycle ops and 17-cycle MUL/DIV.
// Ports: clk (rising edge), reset (async, active low),
//   bus (alu16_mc_if.slave): start/op/S/T request, Y_lo/Y_hi result,
//   busy, done pulse, C/V/N/Z flags.
// Macro ALU16_DIV_EN: when defined op E divides; otherwise op E is reserved.
module alu16_mc
    import alu16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    alu16_mc_if.slave   bus
);

    state_e       r_state;
    logic [W-1:0] r_y_lo;
    logic [W-1:0] r_y_hi;
    logic         r_c, r_v, r_n, r_z, r_done;
`ifdef ALU16_DIV_EN
    logic         r_is_div;
    logic         r_dz;
`endif

    logic         w_accept, w_iter_op, w_load, w_last;
    logic [W-1:0] w_it_hi, w_it_lo;
    logic [W-1:0] w_res;
    logic         w_c, w_v;
    logic [W:0]   w_add, w_sub, w_inc, w_dec;

    // FIN has busy=0, so a new request is taken there as well
    assign w_accept  = bus.start && (r_state != ST_ITER);
    assign w_iter_op = is_iter_op(bus.op);
    assign w_load    = w_accept && w_iter_op;

    alu16_iter u_iter (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_step  (r_state == ST_ITER),
`ifdef ALU16_DIV_EN
        .i_div   (bus.op == OP_DIV),
`endif
        .i_a     (bus.S),
        .i_b     (bus.T),
        .o_last  (w_last),
        .o_hi    (w_it_hi),
        .o_lo    (w_it_lo)
    );

    assign w_add = {1'b0, bus.S} + {1'b0, bus.T};
    assign w_sub = {1'b0, bus.S} - {1'b0, bus.T};
    assign w_inc = {1'b0, bus.S} + 17'd1;
    assign w_dec = {1'b0, bus.S} - 17'd1;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.op)
            OP_PASS_S: w_res = bus.S;
            OP_PASS_T: w_res = bus.T;
            OP_ADD: begin
                w_res = w_add[W-1:0];
                w_c   = w_add[W];
                w_v   = (bus.S[W-1] == bus.T[W-1]) && (w_add[W-1] != bus.S[W-1]);
            end
            OP_SUB: begin
                w_res = w_sub[W-1:0];
                w_c   = w_sub[W];
                w_v   = (bus.S[W-1] != bus.T[W-1]) && (w_sub[W-1] != bus.S[W-1]);
            end
            OP_INC: begin
                w_res = w_inc[W-1:0];
                w_c   = w_inc[W];
                w_v   = !bus.S[W-1] && w_inc[W-1];
            end
            OP_DEC: begin
                w_res = w_dec[W-1:0];
                w_c   = w_dec[W];
                w_v   = bus.S[W-1] && !w_dec[W-1];
            end
            OP_AND: w_res = bus.S & bus.T;
            OP_OR:  w_res = bus.S | bus.T;
            OP_XOR: w_res = bus.S ^ bus.T;
            OP_NOT: w_res = ~bus.S;
            OP_SHL: begin
                w_res = {bus.S[W-2:0], 1'b0};
                w_c   = bus.S[W-1];
            end
            OP_SHR: begin
                w_res = {1'b0, bus.S[W-1:1]};
                w_c   = bus.S[0];
            end
            OP_ASR: begin
                w_res = {bus.S[W-1], bus.S[W-1:1]};
                w_c   = bus.S[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_y_lo   <= '0;
            r_y_hi   <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_done   <= 1'b0;
`ifdef ALU16_DIV_EN
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_ITER: begin
                    if (w_last) begin
                        // capture the 16th step's result in the same edge
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                        r_y_lo  <= w_it_lo;
                        r_y_hi  <= w_it_hi;
                        r_n     <= w_it_lo[W-1];
                        r_z     <= (w_it_lo == '0);
`ifdef ALU16_DIV_EN
                        if (r_is_div) begin
                            r_c <= 1'b0;
                            r_v <= r_dz;
                        end else begin
                            r_c <= |w_it_hi;
                            r_v <= |w_it_hi;
                        end
`else
                        r_c     <= |w_it_hi;
                        r_v     <= |w_it_hi;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        if (w_iter_op) begin
                            r_state  <= ST_ITER;
`ifdef ALU16_DIV_EN
                            r_is_div <= (bus.op == OP_DIV);
                            r_dz     <= (bus.T == '0);
`endif
                        end else begin
                            r_done <= 1'b1;
                            r_y_lo <= w_res;
                            r_y_hi <= '0;
                            r_c    <= w_c;
                            r_v    <= w_v;
                            r_n    <= w_res[W-1];
                            r_z    <= (w_res == '0);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.Y_lo = r_y_lo;
    assign bus.Y_hi = r_y_hi;
    assign bus.C    = r_c;
    assign bus.V    = r_v;
    assign bus.N    = r_n;
    assign bus.Z    = r_z;
    assign bus.done = r_done;
    assign bus.busy = (r_state == ST_ITER);

endmodule

// File: tb/tb_alu16_mc.sv
// tb_alu16_mc: directed self-checking bench for alu16_mc.
// Honours ALU16_DIV_EN to select divide or reserved expectations for op E.
module tb_alu16_mc;
    import alu16_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu16_mc_if bus();

    alu16_mc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] s;
        logic [15:0] t;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  f;    // {C,V,N,Z}
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] s, t, lo, hi,
                                input logic [3:0] f, input int lat);
        vec_t v;
        v.op = op; v.s = s; v.t = t; v.lo = lo; v.hi = hi; v.f = f; v.lat = lat;
        return v;
    endfunction

    function automatic logic [3:0] flags();
        return {bus.C, bus.V, bus.N, bus.Z};
    endfunction

    // Caller is at a negedge. Returns cycles from accepting edge to done
    // (0 on timeout) and how many sampled cycles showed busy.
    task automatic do_op(input logic [3:0] op, input logic [15:0] s, t,
                         output int lat, output int nbusy);
        bus.start = 1'b1; bus.op = op; bus.S = s; bus.T = t;
        lat = 0; nbusy = 0;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0;
                bus.S = ~s;
                bus.T = ~t;
            end
            if (bus.busy) nbusy++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, nbusy, k, ndone;

        vecs.push_back(mk(4'h2, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 4'b0110, 1));
        vecs.push_back(mk(4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'h0, 4'b1010, 1));
        vecs.push_back(mk(4'h2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 4'b1001, 1));
        vecs.push_back(mk(4'h3, 16'h8000, 16'h0001, 16'h7FFF, 16'h0, 4'b0100, 1));
        vecs.push_back(mk(4'h4, 16'hFFFF, 16'h0000, 16'h0000, 16'h0, 4'b1001, 1));
        vecs.push_back(mk(4'h4, 16'h7FFF, 16'h0000, 16'h8000, 16'h0, 4'b0110, 1));
        vecs.push_back(mk(4'h5, 16'h0000, 16'h0000, 16'hFFFF, 16'h0, 4'b1010, 1));
        vecs.push_back(mk(4'h5, 16'h8000, 16'h0000, 16'h7FFF, 16'h0, 4'b0100, 1));
        vecs.push_back(mk(4'h6, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0, 4'b0000, 1));
        vecs.push_back(mk(4'h7, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0, 4'b0010, 1));
        vecs.push_back(mk(4'h8, 16'hF0F0, 16'h3C3C, 16'hCCCC, 16'h0, 4'b0010, 1));
        vecs.push_back(mk(4'h9, 16'hF0F0, 16'h3C3C, 16'h0F0F, 16'h0, 4'b0000, 1));
        vecs.push_back(mk(4'hA, 16'h8001, 16'h0000, 16'h0002, 16'h0, 4'b1000, 1));
        vecs.push_back(mk(4'hB, 16'h8001, 16'h0000, 16'h4000, 16'h0, 4'b1000, 1));
        vecs.push_back(mk(4'hC, 16'h8001, 16'h0000, 16'hC000, 16'h0, 4'b1010, 1));
        vecs.push_back(mk(4'h0, 16'h1234, 16'h0000, 16'h1234, 16'h0, 4'b0000, 1));
        vecs.push_back(mk(4'h1, 16'h1234, 16'h0000, 16'h0000, 16'h0, 4'b0001, 1));
        vecs.push_back(mk(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0, 4'b0001, 1));
        vecs.push_back(mk(4'hD, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1100, 17));
        vecs.push_back(mk(4'hD, 16'h0003, 16'h0005, 16'h000F, 16'h0, 4'b0000, 17));
`ifdef ALU16_DIV_EN
        vecs.push_back(mk(4'hE, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 4'b0000, 17));
        vecs.push_back(mk(4'hE, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 4'b0110, 17));
        vecs.push_back(mk(4'hE, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 4'b0000, 17));
`else
        vecs.push_back(mk(4'hE, 16'h0064, 16'h0007, 16'h0000, 16'h0, 4'b0001, 1));
        vecs.push_back(mk(4'hE, 16'h0064, 16'h0000, 16'h0000, 16'h0, 4'b0001, 1));
`endif

        reset = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.S = '0; bus.T = '0;
        @(negedge clk);
        check("rst_lo", 32'(bus.Y_lo), 32'h0);
        check("rst_hi", 32'(bus.Y_hi), 32'h0);
        check("rst_flags", 32'(flags()), 32'h0);
        check("rst_busy_done", {30'b0, bus.busy, bus.done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // back-to-back: each request lands in the previous done cycle
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].s, vecs[i].t, lat, nbusy);
            check($sformatf("v%0d_op%0h_lat", i, vecs[i].op), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_op%0h_busy", i, vecs[i].op), 32'(nbusy), 32'(vecs[i].lat - 1));
            check($sformatf("v%0d_op%0h_lo", i, vecs[i].op), 32'(bus.Y_lo), 32'(vecs[i].lo));
            check($sformatf("v%0d_op%0h_hi", i, vecs[i].op), 32'(bus.Y_hi), 32'(vecs[i].hi));
            check($sformatf("v%0d_op%0h_cvnz", i, vecs[i].op), 32'(flags()), 32'(vecs[i].f));
        end

        // start during ITER must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'hD; bus.S = 16'h0003; bus.T = 16'h0005;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        repeat (3) begin @(negedge clk); k++; end
        bus.start = 1'b1; bus.op = 4'h2; bus.S = 16'h0001; bus.T = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        k++;
        bus.start = 1'b0;
        check("ign_busy", 32'(bus.busy), 32'h1);
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ign_lat", 32'(k), 32'd17);
        check("ign_lo", 32'(bus.Y_lo), 32'h000F);
        check("ign_hi", 32'(bus.Y_hi), 32'h0);
        @(negedge clk);
        check("ign_done_pulse", 32'(bus.done), 32'h0);
        check("ign_hold_lo", 32'(bus.Y_lo), 32'h000F);

        // async reset at iteration 8 of a MUL
        bus.start = 1'b1; bus.op = 4'hD; bus.S = 16'hFFFF; bus.T = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("arst_lo", 32'(bus.Y_lo), 32'h0);
        check("arst_hi", 32'(bus.Y_hi), 32'h0);
        check("arst_flags", 32'(flags()), 32'h0);
        check("arst_busy_done", {30'b0, bus.busy, bus.done}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'h0);
        do_op(4'h2, 16'h0001, 16'h0002, lat, nbusy);
        check("post_rst_lat", 32'(lat), 32'd1);
        check("post_rst_lo", 32'(bus.Y_lo), 32'h0003);
        check("post_rst_flags", 32'(flags()), 32'h0);
        do_op(4'hD, 16'h0100, 16'h0100, lat, nbusy);
        check("post_rst_mul_lat", 32'(lat), 32'd17);
        check("post_rst_mul", {bus.Y_hi, bus.Y_lo}, 32'h0001_0000);
        check("post_rst_mul_cvnz", 32'(flags()), 32'b1101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
